// File: rtl/pc_rs_pkg.sv
// pc_rs_pkg: operation encoding and default parameters for the
// program counter with return-address stack.
package pc_rs_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_CALL = 2'd1,
        OP_RSVD = 2'd2,
        OP_RET  = 2'd3
    } op_e;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_RESET_PC = 240;
    localparam int unsigned DEF_INC      = 4;

endpackage

// File: rtl/pc_rs_lifo.sv
// pc_rs_lifo: return-address stack storage, write pointer and fill level.
// Build option PC_RS_WRAP_EN: a push into a full stack overwrites the
// oldest entry instead of being dropped.
module pc_rs_lifo
    import pc_rs_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

`ifdef PC_RS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // When full, wp points at the oldest entry, so a wrapping push
    // overwrites exactly that slot.
    assign do_push = push && (!full || WRAP);
    assign do_pop  = pop && !empty && !push;
    assign rp      = wp - PW'(1);
    assign rdata   = mem[rp];

    // Pointer and level tracking; level saturates at DEPTH on wrapping pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            level <= '0;
        end else if (do_push) begin
            wp <= wp + PW'(1);
            if (!full) begin
                level <= level + LW'(1);
            end
        end else if (do_pop) begin
            wp    <= rp;
            level <= level - LW'(1);
        end
    end

    // Entry storage is not reset; a write is suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wp] <= wdata;
        end
    end

endmodule

// File: rtl/program_counter_rs.sv
// program_counter_rs: program counter with CALL/RET return-address stack
// and sticky overflow/underflow flags.
// Build option PC_RS_WRAP_EN (in pc_rs_lifo): circular overwrite on CALL
// into a full stack; default build drops the push.
module program_counter_rs
    import pc_rs_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned INC      = DEF_INC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         address,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         pcout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    op_e              op_dec;
    logic             is_call;
    logic             is_ret;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] top_entry;

    assign op_dec   = op_e'(op);
    assign is_call  = (op_dec == OP_CALL);
    assign is_ret   = (op_dec == OP_RET);
    assign ret_addr = pcout + WIDTH'(INC);

    pc_rs_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (is_call),
        .pop   (is_ret),
        .wdata (ret_addr),
        .rdata (top_entry),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // PC update: RET reloads from the stack top, every other op loads address when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcout <= WIDTH'(RESET_PC);
        end else if (is_ret) begin
            if (!empty) begin
                pcout <= top_entry;
            end
        end else if (en) begin
            pcout <= address;
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (is_call && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (is_ret && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_program_counter_rs.sv
// tb_program_counter_rs: directed vector table plus hand-written sequences
// for stack overflow, underflow clearing and asynchronous reset.
module tb_program_counter_rs;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [31:0] address;
    logic        clr_err;
    logic [31:0] pcout;
    logic [2:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    program_counter_rs dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .address   (address),
        .clr_err   (clr_err),
        .pcout     (pcout),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [31:0] address;
        logic        clr_err;
        logic [31:0] exp_pc;
        logic [2:0]  exp_level;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] o, input logic [31:0] a, input logic c);
        en = e;
        op = o;
        address = a;
        clr_err = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [2:0] lv,
                             input logic ovf, input logic udf);
        chk({tag, ".pcout"}, pcout, pc);
        chk({tag, ".level"}, {29'd0, level}, {29'd0, lv});
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, (lv == 3'd0)});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, (lv == 3'd4)});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ovf});
        chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, udf});
    endtask

    vec_t vecs [15];
    logic [31:0] exp_ret [4];

    initial begin
        // en, op, address, clr_err -> pc, level, ovf, udf
        vecs[0]  = '{1'b1, 2'd0, 32'h100, 1'b0, 32'h100, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 32'h555, 1'b0, 32'h100, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 32'h180, 1'b0, 32'h180, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 32'h100, 1'b0, 32'h100, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 32'h200, 1'b0, 32'h200, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'd3, 32'h999, 1'b0, 32'h104, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 32'h777, 1'b0, 32'h104, 3'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 32'h400, 1'b0, 32'h400, 3'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'd3, 32'h000, 1'b0, 32'h108, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'd3, 32'h123, 1'b0, 32'h108, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'd3, 32'h123, 1'b0, 32'h108, 3'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 2'd0, 32'h300, 1'b0, 32'h300, 3'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 32'h000, 1'b1, 32'h300, 3'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 2'd3, 32'h000, 1'b1, 32'h300, 3'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 2'd0, 32'h000, 1'b1, 32'h300, 3'd0, 1'b0, 1'b0};

`ifdef PC_RS_WRAP_EN
        exp_ret = '{32'h54, 32'h44, 32'h34, 32'h24};
`else
        exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14};
`endif

        rst = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_state("reset", 32'd240, 3'd0, 1'b0, 1'b0);
        step();
        chk_state("idle", 32'd240, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].en, vecs[i].op, vecs[i].address, vecs[i].clr_err);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_level,
                      vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // Five CALLs into a four-entry stack
        drive(1'b1, 2'd0, 32'h10, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd1, 32'h10 * (i + 2), 1'b0);
            step();
            chk_state($sformatf("call%0d", i), 32'h10 * (i + 2),
                      (i < 4) ? 3'(i + 1) : 3'd4, (i == 4), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd3, 32'hdead, 1'b0);
            step();
            chk_state($sformatf("ret%0d", i), exp_ret[i], 3'(3 - i), 1'b1, 1'b0);
        end
        drive(1'b0, 2'd3, 32'h0, 1'b0);
        step();
        chk_state("ret_empty", exp_ret[3], 3'd0, 1'b1, 1'b1);
        drive(1'b0, 2'd0, 32'h0, 1'b1);
        step();
        chk_state("clr_both", exp_ret[3], 3'd0, 1'b0, 1'b0);

        // Asynchronous reset between edges after two CALLs, with flags set
        drive(1'b0, 2'd3, 32'h0, 1'b0);
        step();
        drive(1'b1, 2'd1, 32'h500, 1'b0);
        step();
        drive(1'b1, 2'd1, 32'h600, 1'b0);
        step();
        chk_state("pre_rst", 32'h600, 3'd2, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 32'd240, 3'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step();
        chk_state("post_rst", 32'd240, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 32'h777, 1'b0);
        step();
        chk_state("post_rst_ret", 32'd240, 3'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
